pll_drp_sequencer: RTL and testbench
====================================

Name: pll_drp_sequencer

Overview:
- Reconfiguration controller for the PLL model's dynamic reconfiguration port (DRP).
- On a start request it holds the PLL in reset and walks a table of NUM_ENTRIES register updates. Each update is a read-modify-write over DRP.
- It then releases the PLL reset, waits for LOCKED, and signals completion.
- Sits between user logic (or the testbench) and the PLLE2_ADV/MMCM wrapper's DADDR/DEN/DWE/DI/DO/DRDY/RST/LOCKED pins. It runs in the DCLK domain.

Parameters:
- NUM_ENTRIES, 23, number of table entries per reconfiguration; legal range 1..32.
- IDX_W, 5, width of the table index; must satisfy 2**IDX_W >= NUM_ENTRIES.
- TIMEOUT_CYCLES, 1024, DRDY/LOCKED wait limit; used only with the optional feature.

Ports:
- DCLK  input  1  single clock; DRP clock, clocks all logic.
- RST  input  1  synchronous, active-high reset of this block.
- SEN  input  1  start request, sampled only in IDLE.
- SRDY  output  1  one-cycle pulse when reconfiguration is complete and the PLL is locked.
- BUSY  output  1  high from the cycle after an accepted SEN until the SRDY cycle inclusive.
- TBL_IDX  output  IDX_W  current table index.
- TBL_ENTRY  input  39  combinational table read, same cycle as TBL_IDX. Format: [38:32] DRP address, [31:16] keep-mask (1 = keep old bit), [15:0] new data.
- PLL_RST  output  1  drives the PLL RST pin.
- PLL_LOCKED  input  1  from the PLL LOCKED pin.
- DADDR  output  7  DRP address.
- DEN  output  1  DRP enable.
- DWE  output  1  DRP write enable.
- DI  output  16  DRP write data.
- DO  input  16  DRP read data, valid when DRDY=1.
- DRDY  input  1  DRP access complete.
- ERR  output  1  sticky timeout flag; only with the optional feature, otherwise tied 0.

Behaviour:

Registered outputs:
- All outputs are registered.

Reset values (while RST=1):
- State IDLE, TBL_IDX=0.
- PLL_RST=1, so the PLL is held in reset while the controller is in reset.
- SRDY=0, BUSY=0, DEN=0, DWE=0, DADDR=0, DI=0, ERR=0.
- RST mid-operation aborts immediately to these values. Nothing is completed and no DEN is issued.

States:
- IDLE: PLL_RST=0, BUSY=0. If SEN=1, go to ASSERT with TBL_IDX=0. SEN in any other state is ignored and not queued.
- ASSERT: PLL_RST=1, BUSY=1; one cycle, then go to READ.
- READ: DEN=1, DWE=0, DADDR=TBL_ENTRY[38:32] for exactly one cycle; then go to WAIT_R.
- WAIT_R: DEN=0. On DRDY=1, capture DO into a 16-bit holding register and go to WRITE.
- WRITE: DEN=1, DWE=1, DADDR unchanged, DI=(held_DO & mask) | (data & ~mask) for one cycle; then go to WAIT_W.
- WAIT_W: DEN=0, DWE=0. On DRDY=1: if TBL_IDX==NUM_ENTRIES-1, go to RELEASE; otherwise TBL_IDX+1 and go to READ.
- RELEASE: PLL_RST=0; one cycle, then go to WAIT_LOCK.
- WAIT_LOCK: on PLL_LOCKED=1, go to DONE. LOCKED is never sampled in the release cycle, so a stale lock cannot end the sequence.
- DONE: SRDY=1 for one cycle, BUSY=1; then go to IDLE with BUSY=0.

DRP rules:
- PLL_RST stays 1 continuously from ASSERT through WAIT_W of the last entry.
- DEN is a single-cycle pulse and is never reissued before DRDY.
- DRDY in any state other than WAIT_R/WAIT_W is ignored.
- DRDY in the same cycle as DEN is not possible by DRP protocol and is ignored.

Timing and arithmetic:
- Minimum latency from accepted SEN to SRDY, with DRDY one cycle after DEN and LOCKED already high: 1 + 4·NUM_ENTRIES + 3 cycles.
- TBL_IDX never exceeds NUM_ENTRIES-1; there is no wrap-around.
- The mask merge is pure bitwise; no arithmetic on data.

Optional Feature:

Macro: PLL_DRP_TIMEOUT_EN.

With the macro defined:
- A counter runs in WAIT_R, WAIT_W and WAIT_LOCK; it clears on every state entry.
- Reaching TIMEOUT_CYCLES sets ERR=1 (sticky until RST), forces DEN=DWE=0, and goes to IDLE with PLL_RST=0. SRDY is not pulsed.
- A later SEN is still accepted; ERR remains set.

Without the macro:
- No counter exists, ERR is constant 0, and WAIT states may wait indefinitely.

Test Plan:
- Single entry {addr 0x08, mask 0x1000, data 0x0041}, DO=0xFFFF, DRDY at DEN+1, LOCKED high 5 cycles after release:
  - expect read at 0x08, then write DI=0x1041.
  - expect PLL_RST high from SEN+1 until release.
  - expect one SRDY pulse; BUSY drops the cycle after SRDY.
- NUM_ENTRIES=3, addresses 0x08/0x09/0x14, DRDY delayed 4 cycles:
  - expect 6 DEN pulses in order R,W,R,W,R,W; TBL_IDX 0→1→2; no DEN while waiting.
- SEN pulsed repeatedly during BUSY, plus spurious DRDY in READ and WAIT_LOCK:
  - expect no restart, no extra DEN, and exactly one SRDY.
- RST asserted during WAIT_W of entry 1:
  - next cycle DEN=0, BUSY=0, PLL_RST=1.
  - after RST release: IDLE, PLL_RST=0; a new SEN restarts from TBL_IDX=0.
- LOCKED stuck high through release:
  - SRDY no earlier than RELEASE+2.
  - with LOCKED low for 100 cycles, SRDY occurs 1 cycle after LOCKED rises.
- With PLL_DRP_TIMEOUT_EN and TIMEOUT_CYCLES=16, DRDY never returned:
  - ERR=1 after 16 WAIT_R cycles; state IDLE, PLL_RST=0, no SRDY.
  - ERR stays 1 through a subsequent successful run.

Source files
------------

// File: rtl/pll_drp_sequencer_if.sv
// rtl/pll_drp_sequencer_if.sv - DRP bus between the reconfiguration sequencer and the PLL wrapper
//
// Purpose: bundles the PLLE2_ADV/MMCM dynamic reconfiguration port pins.
// Signals:
//   DADDR [6:0]  register address      (master -> slave)
//   DEN          access enable pulse    (master -> slave)
//   DWE          write enable           (master -> slave)
//   DI    [15:0] write data             (master -> slave)
//   DO    [15:0] read data, valid with DRDY (slave -> master)
//   DRDY         access complete        (slave -> master)
// Modports: master (sequencer side), slave (PLL side).

interface pll_drp_sequencer_if;
  logic [6:0]  DADDR;
  logic        DEN;
  logic        DWE;
  logic [15:0] DI;
  logic [15:0] DO;
  logic        DRDY;

  modport master (
    output DADDR, DEN, DWE, DI,
    input  DO, DRDY
  );

  modport slave (
    input  DADDR, DEN, DWE, DI,
    output DO, DRDY
  );
endinterface

// File: rtl/pll_drp_sequencer.sv
// rtl/pll_drp_sequencer.sv - PLL DRP reconfiguration sequencer (read-modify-write table walker)
//
// Purpose: on SEN, holds the PLL in reset, walks NUM_ENTRIES table entries doing
// a DRP read-modify-write for each, releases the PLL reset, waits for LOCKED and
// pulses SRDY. Everything runs in the DCLK domain.
// Ports:
//   DCLK        DRP clock, clocks all logic
//   RST         synchronous active-high reset
//   SEN         start request, sampled only when idle
//   SRDY        one-cycle completion pulse (PLL locked)
//   BUSY        high from the cycle after an accepted SEN through the SRDY cycle
//   TBL_IDX     current table index
//   TBL_ENTRY   table word for TBL_IDX: [38:32] addr, [31:16] keep-mask, [15:0] data
//   PLL_RST     PLL reset pin
//   PLL_LOCKED  PLL lock indicator
//   drp         DRP bus (master modport)
//   ERR         sticky timeout flag
// Optional feature: define PLL_DRP_TIMEOUT_EN to bound the DRDY/LOCKED waits by
// TIMEOUT_CYCLES; without it ERR is constant 0 and the waits are unbounded.

module pll_drp_sequencer #(
  parameter int NUM_ENTRIES    = 23,
  parameter int IDX_W          = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 DCLK,
  input  logic                 RST,
  input  logic                 SEN,
  output logic                 SRDY,
  output logic                 BUSY,
  output logic [IDX_W-1:0]     TBL_IDX,
  input  logic [38:0]          TBL_ENTRY,
  output logic                 PLL_RST,
  input  logic                 PLL_LOCKED,
  pll_drp_sequencer_if.master  drp,
  output logic                 ERR
);

  if (NUM_ENTRIES < 1 || NUM_ENTRIES > 32 || (2 ** IDX_W) < NUM_ENTRIES || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("pll_drp_sequencer: illegal parameter combination");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    st_idle,
    st_assert,
    st_read,
    st_wait_r,
    st_write,
    st_wait_w,
    st_release,
    st_wait_lock,
    st_done
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             srdy_q, busy_q, pll_rst_q, den_q, dwe_q;
  logic [6:0]       daddr_q;
  logic [15:0]      di_q;
  logic             timeout;

  wire [15:0] keep_mask = TBL_ENTRY[31:16];
  wire [15:0] new_data  = TBL_ENTRY[15:0];

`ifdef PLL_DRP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             in_wait;

  assign in_wait = (state == st_wait_r) || (state == st_wait_w) || (state == st_wait_lock);
  // Fires on the TIMEOUT_CYCLES-th consecutive cycle spent in the same wait state.
  assign timeout = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge DCLK) begin
    if (RST) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      // Clears on every state change, so each wait gets the full budget.
      if (in_wait && (state_n == state)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timeout && (state_n == st_idle)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ERR = err_q;
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx_q;
    case (state)
      st_idle: begin
        if (SEN) begin
          state_n = st_assert;
          idx_n   = '0;
        end
      end
      st_assert: state_n = st_read;
      st_read:   state_n = st_wait_r;
      st_wait_r: begin
        if (drp.DRDY) begin
          state_n = st_write;
        end else if (timeout) begin
          state_n = st_idle;
        end
      end
      st_write:  state_n = st_wait_w;
      st_wait_w: begin
        if (drp.DRDY) begin
          if (idx_q == LAST_IDX) begin
            state_n = st_release;
          end else begin
            idx_n   = idx_q + IDX_W'(1);
            state_n = st_read;
          end
        end else if (timeout) begin
          state_n = st_idle;
        end
      end
      // LOCKED is deliberately not looked at here: it may still be stale from
      // before the reconfiguration.
      st_release: state_n = st_wait_lock;
      st_wait_lock: begin
        if (PLL_LOCKED) begin
          state_n = st_done;
        end else if (timeout) begin
          state_n = st_idle;
        end
      end
      st_done: state_n = st_idle;
      default: state_n = st_idle;
    endcase
  end

  // Output registers are loaded from the next state so they line up with the
  // state they belong to.
  always_ff @(posedge DCLK) begin
    if (RST) begin
      state     <= st_idle;
      idx_q     <= '0;
      srdy_q    <= 1'b0;
      busy_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
    end else begin
      state     <= state_n;
      idx_q     <= idx_n;
      srdy_q    <= (state_n == st_done);
      busy_q    <= (state_n != st_idle);
      pll_rst_q <= (state_n == st_assert) || (state_n == st_read) || (state_n == st_wait_r) ||
                   (state_n == st_write)  || (state_n == st_wait_w);
      den_q     <= (state_n == st_read) || (state_n == st_write);
      dwe_q     <= (state_n == st_write);
      if (state == st_read) begin
        daddr_q <= TBL_ENTRY[38:32];
      end
      // di_q doubles as the read holding register: the merge is done as DO is
      // captured, so DI is ready in the WRITE cycle.
      if ((state == st_wait_r) && drp.DRDY) begin
        di_q <= (drp.DO & keep_mask) | (new_data & ~keep_mask);
      end
    end
  end

  // The table word only becomes valid once TBL_IDX has advanced, i.e. in the
  // READ cycle itself, so the read address comes straight from the table read
  // of the registered index; daddr_q holds it for the WRITE and afterwards.
  assign drp.DADDR = (state == st_read) ? TBL_ENTRY[38:32] : daddr_q;
  assign drp.DEN   = den_q;
  assign drp.DWE   = dwe_q;
  assign drp.DI    = di_q;
  assign SRDY      = srdy_q;
  assign BUSY      = busy_q;
  assign PLL_RST   = pll_rst_q;
  assign TBL_IDX   = idx_q;

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// tb/tb_pll_drp_sequencer.sv - self-checking bench for pll_drp_sequencer (3-entry table)

module tb_pll_drp_sequencer;

  logic        DCLK = 1'b0;
  logic        rst = 1'b1;
  logic        sen = 1'b0;
  logic        locked = 1'b0;
  logic        SRDY, BUSY, PLL_RST, ERR;
  logic [4:0]  TBL_IDX;
  logic [38:0] TBL_ENTRY;

  pll_drp_sequencer_if bus ();

  pll_drp_sequencer #(
    .NUM_ENTRIES(3),
    .IDX_W(5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .DCLK(DCLK),
    .RST(rst),
    .SEN(sen),
    .SRDY(SRDY),
    .BUSY(BUSY),
    .TBL_IDX(TBL_IDX),
    .TBL_ENTRY(TBL_ENTRY),
    .PLL_RST(PLL_RST),
    .PLL_LOCKED(locked),
    .drp(bus),
    .ERR(ERR)
  );

  always #5 DCLK = ~DCLK;

  int checks = 0;
  int failures = 0;

  logic [38:0] tbl [3] = '{{7'h08, 16'h1000, 16'h0041},
                           {7'h09, 16'hFF00, 16'h00AB},
                           {7'h14, 16'h0F0F, 16'hFFFF}};
  logic [6:0]  e_addr [3] = '{7'h08, 7'h09, 7'h14};
  logic [15:0] e_di   [3] = '{16'h1041, 16'h12AB, 16'hF5F3};

  assign TBL_ENTRY = (TBL_IDX < 5'd3) ? tbl[TBL_IDX[1:0]] : 39'h0;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] di;
    logic [4:0]  idx;
  } drp_t;

  drp_t exp_q [$];

  int          drdy_delay = 1;
  bit          drdy_enable = 1'b1;
  logic        slave_drdy = 1'b0;
  logic        spur_drdy = 1'b0;
  logic [15:0] slave_do = 16'h0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [6:0]  pend_addr = 7'h0;

  assign bus.DRDY = slave_drdy | spur_drdy;
  assign bus.DO   = slave_do;

  function automatic logic [15:0] pll_reg(input logic [6:0] a);
    case (a)
      7'h08:   return 16'hFFFF;
      7'h09:   return 16'h1234;
      7'h14:   return 16'hA5C3;
      default: return 16'h0000;
    endcase
  endfunction

  // PLL-side DRP model and scoreboard sink.
  always @(negedge DCLK) begin
    drp_t e;
    slave_drdy = 1'b0;
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      checks++;
      if (bus.DEN !== 1'b0) begin
        failures++;
        $display("FAIL den_while_waiting den=%b required=0 t=%0t", bus.DEN, $time);
      end
      pend_cnt--;
      if (pend_cnt == 0) begin
        slave_drdy = 1'b1;
        slave_do   = pll_reg(pend_addr);
        pend       = 1'b0;
      end
    end else if (bus.DEN === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_den we=%b addr=%h idx=%0d required=no_access t=%0t",
                 bus.DWE, bus.DADDR, TBL_IDX, $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.DWE !== e.we || bus.DADDR !== e.addr || TBL_IDX !== e.idx ||
            (e.we && bus.DI !== e.di)) begin
          failures++;
          $display("FAIL drp_txn we=%b addr=%h di=%h idx=%0d required we=%b addr=%h di=%h idx=%0d",
                   bus.DWE, bus.DADDR, bus.DI, TBL_IDX, e.we, e.addr, e.di, e.idx);
        end
      end
      if (drdy_enable) begin
        pend      = 1'b1;
        pend_cnt  = drdy_delay;
        pend_addr = bus.DADDR;
      end
    end
  end

  task automatic push_run();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{we: 1'b0, addr: e_addr[i], di: 16'h0, idx: 5'(i)});
      exp_q.push_back('{we: 1'b1, addr: e_addr[i], di: e_di[i], idx: 5'(i)});
    end
  endtask

  // Cycle 1 is the first cycle after the one in which SEN was sampled.
  task automatic run_seq(input int lock_delay, output int rel_cyc, output int srdy_cyc,
                         output int srdy_cnt, output int busy_err, output logic busy_after);
    rel_cyc = -1; srdy_cyc = -1; srdy_cnt = 0; busy_err = 0; busy_after = 1'bx;
    push_run();
    @(negedge DCLK);
    locked = (lock_delay == 0);
    sen = 1'b1;
    @(negedge DCLK);
    sen = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      if (rel_cyc < 0 && PLL_RST !== 1'b1) rel_cyc = c;
      if (srdy_cyc < 0 && BUSY !== 1'b1) busy_err++;
      if (lock_delay > 0 && rel_cyc > 0 && c == rel_cyc + lock_delay) locked = 1'b1;
      if (SRDY === 1'b1) begin
        srdy_cnt++;
        if (srdy_cyc < 0) srdy_cyc = c;
      end
      if (srdy_cyc > 0 && c == srdy_cyc + 1) begin
        busy_after = BUSY;
        break;
      end
      @(negedge DCLK);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge DCLK);
    checks++;
    if ({SRDY, BUSY, bus.DEN, bus.DWE, PLL_RST, ERR} !== 6'b000010 || bus.DADDR !== 7'h0 ||
        bus.DI !== 16'h0 || TBL_IDX !== 5'd0) begin
      failures++;
      $display("FAIL reset_values srdy=%b busy=%b den=%b dwe=%b pll_rst=%b err=%b daddr=%h di=%h idx=%0d required 0 0 0 0 1 0 00 0000 0",
               SRDY, BUSY, bus.DEN, bus.DWE, PLL_RST, ERR, bus.DADDR, bus.DI, TBL_IDX);
    end
    rst = 1'b0;
    repeat (2) @(negedge DCLK);
    checks++;
    if (PLL_RST !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset pll_rst=%b busy=%b required 0 0", PLL_RST, BUSY);
    end
  endtask

  task automatic test_single();
    int rel, sc, cnt, be;
    logic ba;
    drdy_delay = 1;
    run_seq(5, rel, sc, cnt, be, ba);
    checks++;
    if (rel !== 14) begin failures++; $display("FAIL single_release_cycle got=%0d required=14", rel); end
    checks++;
    if (sc !== 20) begin failures++; $display("FAIL single_srdy_cycle got=%0d required=20", sc); end
    checks++;
    if (cnt !== 1) begin failures++; $display("FAIL single_srdy_count got=%0d required=1", cnt); end
    checks++;
    if (be !== 0) begin failures++; $display("FAIL single_busy_gaps got=%0d required=0", be); end
    checks++;
    if (ba !== 1'b0) begin failures++; $display("FAIL single_busy_after_srdy got=%b required=0", ba); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL single_missing_txn got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_slow_drdy();
    int rel, sc, cnt, be;
    logic ba;
    drdy_delay = 4;
    run_seq(0, rel, sc, cnt, be, ba);
    checks++;
    if (rel !== 32) begin failures++; $display("FAIL slow_release_cycle got=%0d required=32", rel); end
    checks++;
    if (sc !== 34) begin failures++; $display("FAIL slow_srdy_cycle got=%0d required=34", sc); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL slow_missing_txn got=%0d required=0", exp_q.size()); end
    drdy_delay = 1;
  endtask

  task automatic test_ignore_sen_drdy();
    int rel, sc, cnt, be, busy_seen;
    logic ba;
    bit run_done;
    run_done = 1'b0;
    busy_seen = 0;
    fork
      begin
        run_seq(10, rel, sc, cnt, be, ba);
        run_done = 1'b1;
      end
      begin
        while (!run_done) begin
          @(negedge DCLK);
          spur_drdy = 1'b0;
          if (BUSY === 1'b1) begin
            sen = (SRDY !== 1'b1);
            if ((bus.DEN === 1'b1 && bus.DWE === 1'b0) || (PLL_RST === 1'b0 && SRDY !== 1'b1))
              spur_drdy = 1'b1;
          end
        end
        sen = 1'b0;
        spur_drdy = 1'b0;
      end
    join
    repeat (5) begin
      @(negedge DCLK);
      if (BUSY !== 1'b0) busy_seen++;
    end
    checks++;
    if (sc !== 25) begin failures++; $display("FAIL ignore_srdy_cycle got=%0d required=25", sc); end
    checks++;
    if (cnt !== 1) begin failures++; $display("FAIL ignore_srdy_count got=%0d required=1", cnt); end
    checks++;
    if (busy_seen !== 0) begin failures++; $display("FAIL ignore_restart busy_cycles=%0d required=0", busy_seen); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL ignore_missing_txn got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_midrun();
    int rel, sc, cnt, be;
    bit found;
    logic ba;
    drdy_delay = 4;
    locked = 1'b1;
    found = 1'b0;
    push_run();
    @(negedge DCLK);
    sen = 1'b1;
    @(negedge DCLK);
    sen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.DEN === 1'b1 && bus.DWE === 1'b1 && TBL_IDX === 5'd1) begin
        found = 1'b1;
        break;
      end
      @(negedge DCLK);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midrst_reach_write got=timeout required=write_idx1"); end
    @(negedge DCLK);
    rst = 1'b1;
    @(negedge DCLK);
    checks++;
    if (bus.DEN !== 1'b0 || BUSY !== 1'b0 || PLL_RST !== 1'b1 || TBL_IDX !== 5'd0 || SRDY !== 1'b0) begin
      failures++;
      $display("FAIL midrst_abort den=%b busy=%b pll_rst=%b idx=%0d srdy=%b required 0 0 1 0 0",
               bus.DEN, BUSY, PLL_RST, TBL_IDX, SRDY);
    end
    checks++;
    if (exp_q.size() !== 2) begin failures++; $display("FAIL midrst_remaining_txn got=%0d required=2", exp_q.size()); end
    @(negedge DCLK);
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge DCLK);
    checks++;
    if (PLL_RST !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL midrst_idle pll_rst=%b busy=%b required 0 0", PLL_RST, BUSY);
    end
    drdy_delay = 1;
    run_seq(0, rel, sc, cnt, be, ba);
    checks++;
    if (sc !== 16 || cnt !== 1) begin
      failures++;
      $display("FAIL midrst_restart srdy_cycle=%0d count=%0d required 16 1", sc, cnt);
    end
  endtask

  task automatic test_lock_timing();
    int rel, sc, cnt, be;
    logic ba;
    run_seq(0, rel, sc, cnt, be, ba);
    checks++;
    if (sc !== rel + 2 || sc !== 16) begin
      failures++;
      $display("FAIL lock_stuck_high srdy=%0d release=%0d required srdy=16 release=14", sc, rel);
    end
    run_seq(100, rel, sc, cnt, be, ba);
    checks++;
    if (sc !== 115 || rel !== 14) begin
      failures++;
      $display("FAIL lock_late srdy=%0d release=%0d required srdy=115 release=14", sc, rel);
    end
    checks++;
    if (be !== 0 || ba !== 1'b0) begin
      failures++;
      $display("FAIL lock_late_busy gaps=%0d after=%b required 0 0", be, ba);
    end
  endtask

`ifdef PLL_DRP_TIMEOUT_EN
  task automatic test_timeout();
    int c_idle, srdy_seen, rel, sc, cnt, be;
    logic err_before;
    logic ba;
    c_idle = -1; srdy_seen = 0; err_before = 1'bx;
    drdy_enable = 1'b0;
    exp_q.push_back('{we: 1'b0, addr: e_addr[0], di: 16'h0, idx: 5'd0});
    @(negedge DCLK);
    sen = 1'b1;
    @(negedge DCLK);
    sen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (SRDY === 1'b1) srdy_seen++;
      if (BUSY !== 1'b1) begin
        c_idle = c;
        break;
      end
      err_before = ERR;
      @(negedge DCLK);
    end
    checks++;
    if (c_idle !== 19) begin failures++; $display("FAIL timeout_cycle got=%0d required=19", c_idle); end
    checks++;
    if (ERR !== 1'b1 || err_before !== 1'b0 || PLL_RST !== 1'b0 || srdy_seen !== 0) begin
      failures++;
      $display("FAIL timeout_state err=%b err_before=%b pll_rst=%b srdy=%0d required 1 0 0 0",
               ERR, err_before, PLL_RST, srdy_seen);
    end
    drdy_enable = 1'b1;
    run_seq(0, rel, sc, cnt, be, ba);
    checks++;
    if (sc !== 16 || ERR !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky srdy=%0d err=%b required 16 1", sc, ERR);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_slow_drdy();
    test_ignore_sen_drdy();
    test_reset_midrun();
    test_lock_timing();
`ifdef PLL_DRP_TIMEOUT_EN
    test_timeout();
`else
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL err_tied got=%b required=0", ERR); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
